id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RV32I core. It captures decoded instruction fields and control from ID and presents them to EX, where rs1_ex/rs2_ex/RegWrite drive the forwarding unit and ALU operand muxes. It also detects the one hazard forwarding cannot cover, a load in EX feeding the instruction in ID, and inserts a bubble. Saturating counters record bubbles and flushes for performance debug.

## Interface
- XLEN, 32, datapath width
- CNT_W, 16, width of the stall and flush counters
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- valid_id  in  1  ID holds a real instruction
- pc_id  in  XLEN  PC of the ID instruction
- rs1_id, rs2_id, rd_id  in  5  register indices
- uses_rs1_id, uses_rs2_id  in  1  the instruction actually reads rs1/rs2
- rs1_data_id, rs2_data_id, imm_id  in  XLEN  register-file read data and immediate
- funct3_id  in  3  funct3 field
- alu_op_id  in  4  ALU operation select
- RegWrite_id, MemRead_id, MemWrite_id, MemToReg_id, ALUSrc_id, Branch_id, Jump_id  in  1  control
- hold  in  1  downstream stall; EX contents must not advance
- flush_ex  in  1  squash the instruction entering EX (taken branch or jump)
- valid_ex, pc_ex, rs1_ex, rs2_ex, rd_ex, rs1_data_ex, rs2_data_ex, imm_ex, funct3_ex, alu_op_ex, and all control outputs with the _ex suffix  out  registered copies of the _id inputs
- stall_id  out  1  IF/PC and IF/ID must hold this cycle
- load_use  out  1  a load-use hazard is detected this cycle
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- load_use = valid_ex & MemRead_ex & (rd_ex != 0) & valid_id & ((uses_rs1_id & rd_ex == rs1_id) | (uses_rs2_id & rd_ex == rs2_id)).
- stall_id = hold | (load_use & ~flush_ex).
- Per-edge update, in priority order:
  1. **rst:** all _ex registers become a bubble; both counters are cleared to 0.
  2. **hold:** all _ex registers keep their values. Counters do not change. Upstream keeps flush_ex asserted until hold drops.
  3. **flush_ex:** the _ex registers load a bubble. flush_cnt increments.
  4. **load_use:** the _ex registers load a bubble. stall_cnt increments. ID is held by stall_id and re-presents the same instruction the next cycle.
  5. **Otherwise:** every _ex register loads its _id counterpart. If valid_id=0, a bubble is loaded instead.
- **Bubble contents:** every output is zero, including valid_ex, RegWrite_ex, MemRead_ex, MemWrite_ex, Branch_ex, Jump_ex, rd_ex, rs1_ex, rs2_ex and all data fields. A bubble therefore never triggers forwarding, a write, or a memory access.
- **Counters:** saturate at 2^CNT_W-1 and never wrap.

## Timing
- Register latency is 1 cycle: a value on an _id input at edge N is visible on the matching _ex output after edge N.
- load_use and stall_id are combinational from the current _ex state and _id inputs, in the same cycle. They have no reset value of their own; while rst is held, valid_ex=0, so load_use=0 and stall_id=hold.
- A load-use stall lasts exactly 1 cycle. After the bubble, valid_ex=0 and load_use deasserts, so the consumer enters EX on the following edge. Forwarding then supplies the load data from MEM/WB.
- Back-to-back dependent loads (load then load-use) produce one bubble per dependency. No extra cycles are inserted.
- When hold and load_use are both high, stall_id=1 and the EX contents are retained. No bubble is inserted and stall_cnt is unchanged. The hazard is re-evaluated when hold drops.
- flush_ex with load_use: flush wins, stall_id=0 (unless hold=1), and flush_cnt increments.

## Test plan
- **Reset:** hold rst 2 cycles with random _id inputs -> all _ex outputs are 0, stall_cnt=0, flush_cnt=0, load_use=0.
- **Pass-through:** `addi x5,x0,7` at pc 0x100 (valid_id=1, RegWrite_id=1, rd_id=5) -> next cycle pc_ex=0x100, rd_ex=5, imm_ex=7, valid_ex=1, stall_id=0.
- **Load-use:** `lw x6,0(x1)` followed by `add x7,x6,x2` -> while lw is in EX, load_use=1 and stall_id=1. Next cycle: a bubble (valid_ex=0, rd_ex=0), stall_cnt=1. Following cycle: add in EX, rs1_ex=6.
- **No false hazard:** lw x0 followed by a read of x0, or lw x6 followed by `lui x6` (uses_rs1/2=0) -> load_use=0, no bubble.
- **Flush priority:** flush_ex=1 in the same cycle as load_use=1 -> bubble, flush_cnt=1, stall_cnt=0, stall_id=0.
- **Hold and saturation:** hold=1 for 3 cycles with changing _id inputs -> _ex outputs are unchanged and stall_id=1. Separately, with CNT_W=2, four load-use events -> stall_cnt stays at 3.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection
//
// Captures the decoded ID instruction (fields, operands, control) and presents
// it to EX one cycle later. Detects a load in EX whose destination is read by
// the instruction in ID, and inserts a single bubble while stalling IF/ID.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   *_id                     decoded instruction from ID (valid_id qualifies it)
//   hold                     downstream stall, EX contents frozen
//   flush_ex                 squash the instruction entering EX
//   *_ex                     registered copies of the *_id inputs (bubble = all 0)
//   stall_id                 IF/PC and IF/ID must hold this cycle
//   load_use                 load-use hazard present this cycle
//   stall_cnt, flush_cnt     saturating bubble/flush event counters
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_id,
  input  logic [XLEN-1:0]  pc_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rd_id,
  input  logic             uses_rs1_id,
  input  logic             uses_rs2_id,
  input  logic [XLEN-1:0]  rs1_data_id,
  input  logic [XLEN-1:0]  rs2_data_id,
  input  logic [XLEN-1:0]  imm_id,
  input  logic [2:0]       funct3_id,
  input  logic [3:0]       alu_op_id,
  input  logic             RegWrite_id,
  input  logic             MemRead_id,
  input  logic             MemWrite_id,
  input  logic             MemToReg_id,
  input  logic             ALUSrc_id,
  input  logic             Branch_id,
  input  logic             Jump_id,
  input  logic             hold,
  input  logic             flush_ex,
  output logic             valid_ex,
  output logic [XLEN-1:0]  pc_ex,
  output logic [4:0]       rs1_ex,
  output logic [4:0]       rs2_ex,
  output logic [4:0]       rd_ex,
  output logic [XLEN-1:0]  rs1_data_ex,
  output logic [XLEN-1:0]  rs2_data_ex,
  output logic [XLEN-1:0]  imm_ex,
  output logic [2:0]       funct3_ex,
  output logic [3:0]       alu_op_ex,
  output logic             RegWrite_ex,
  output logic             MemRead_ex,
  output logic             MemWrite_ex,
  output logic             MemToReg_ex,
  output logic             ALUSrc_ex,
  output logic             Branch_ex,
  output logic             Jump_ex,
  output logic             stall_id,
  output logic             load_use,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic [3:0]      alu_op;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            alu_src;
    logic            branch;
    logic            jump;
  } ex_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ex_t              ex_d, ex_q, id_pkt;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  always_comb begin
    id_pkt = '{valid: 1'b1, pc: pc_id, rs1: rs1_id, rs2: rs2_id, rd: rd_id,
               rs1_data: rs1_data_id, rs2_data: rs2_data_id, imm: imm_id,
               funct3: funct3_id, alu_op: alu_op_id, reg_write: RegWrite_id,
               mem_read: MemRead_id, mem_write: MemWrite_id,
               mem_to_reg: MemToReg_id, alu_src: ALUSrc_id,
               branch: Branch_id, jump: Jump_id};
  end

  // A load to x0 never produces a value worth waiting for.
  assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & valid_id &
                    ((uses_rs1_id & (ex_q.rd == rs1_id)) |
                     (uses_rs2_id & (ex_q.rd == rs2_id)));

  // A flush discards the dependent instruction anyway, so no need to hold ID.
  assign stall_id = hold | (load_use & ~flush_ex);

  always_comb begin
    ex_d        = ex_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hold) begin
      ex_d = ex_q;
    end else if (flush_ex) begin
      ex_d = '0;
      if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
    end else if (load_use) begin
      ex_d = '0;
      if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
    end else begin
      ex_d = valid_id ? id_pkt : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign valid_ex    = ex_q.valid;
  assign pc_ex       = ex_q.pc;
  assign rs1_ex      = ex_q.rs1;
  assign rs2_ex      = ex_q.rs2;
  assign rd_ex       = ex_q.rd;
  assign rs1_data_ex = ex_q.rs1_data;
  assign rs2_data_ex = ex_q.rs2_data;
  assign imm_ex      = ex_q.imm;
  assign funct3_ex   = ex_q.funct3;
  assign alu_op_ex   = ex_q.alu_op;
  assign RegWrite_ex = ex_q.reg_write;
  assign MemRead_ex  = ex_q.mem_read;
  assign MemWrite_ex = ex_q.mem_write;
  assign MemToReg_ex = ex_q.mem_to_reg;
  assign ALUSrc_ex   = ex_q.alu_src;
  assign Branch_ex   = ex_q.branch;
  assign Jump_ex     = ex_q.jump;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid_id, uses_rs1_id, uses_rs2_id, hold, flush_ex;
  logic [31:0] pc_id, rs1_data_id, rs2_data_id, imm_id;
  logic [4:0]  rs1_id, rs2_id, rd_id;
  logic [2:0]  funct3_id;
  logic [3:0]  alu_op_id;
  logic        RegWrite_id, MemRead_id, MemWrite_id, MemToReg_id, ALUSrc_id, Branch_id, Jump_id;

  logic        valid_ex, RegWrite_ex, MemRead_ex, MemWrite_ex, MemToReg_ex, ALUSrc_ex, Branch_ex, Jump_ex;
  logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex;
  logic [2:0]  funct3_ex;
  logic [3:0]  alu_op_ex;
  logic        stall_id, load_use;
  logic [15:0] stall_cnt, flush_cnt;

  logic        d2_valid_ex, d2_RegWrite_ex, d2_MemRead_ex, d2_MemWrite_ex, d2_MemToReg_ex;
  logic        d2_ALUSrc_ex, d2_Branch_ex, d2_Jump_ex;
  logic [31:0] d2_pc_ex, d2_rs1_data_ex, d2_rs2_data_ex, d2_imm_ex;
  logic [4:0]  d2_rs1_ex, d2_rs2_ex, d2_rd_ex;
  logic [2:0]  d2_funct3_ex;
  logic [3:0]  d2_alu_op_ex;
  logic        d2_stall_id, d2_load_use;
  logic [1:0]  d2_stall_cnt, d2_flush_cnt;

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .valid_id(valid_id), .pc_id(pc_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rd_id(rd_id), .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .rs1_data_id(rs1_data_id),
    .rs2_data_id(rs2_data_id), .imm_id(imm_id), .funct3_id(funct3_id), .alu_op_id(alu_op_id),
    .RegWrite_id(RegWrite_id), .MemRead_id(MemRead_id), .MemWrite_id(MemWrite_id),
    .MemToReg_id(MemToReg_id), .ALUSrc_id(ALUSrc_id), .Branch_id(Branch_id), .Jump_id(Jump_id),
    .hold(hold), .flush_ex(flush_ex), .valid_ex(valid_ex), .pc_ex(pc_ex), .rs1_ex(rs1_ex),
    .rs2_ex(rs2_ex), .rd_ex(rd_ex), .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
    .imm_ex(imm_ex), .funct3_ex(funct3_ex), .alu_op_ex(alu_op_ex), .RegWrite_ex(RegWrite_ex),
    .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex), .MemToReg_ex(MemToReg_ex),
    .ALUSrc_ex(ALUSrc_ex), .Branch_ex(Branch_ex), .Jump_ex(Jump_ex), .stall_id(stall_id),
    .load_use(load_use), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .valid_id(valid_id), .pc_id(pc_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rd_id(rd_id), .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .rs1_data_id(rs1_data_id),
    .rs2_data_id(rs2_data_id), .imm_id(imm_id), .funct3_id(funct3_id), .alu_op_id(alu_op_id),
    .RegWrite_id(RegWrite_id), .MemRead_id(MemRead_id), .MemWrite_id(MemWrite_id),
    .MemToReg_id(MemToReg_id), .ALUSrc_id(ALUSrc_id), .Branch_id(Branch_id), .Jump_id(Jump_id),
    .hold(hold), .flush_ex(flush_ex), .valid_ex(d2_valid_ex), .pc_ex(d2_pc_ex), .rs1_ex(d2_rs1_ex),
    .rs2_ex(d2_rs2_ex), .rd_ex(d2_rd_ex), .rs1_data_ex(d2_rs1_data_ex), .rs2_data_ex(d2_rs2_data_ex),
    .imm_ex(d2_imm_ex), .funct3_ex(d2_funct3_ex), .alu_op_ex(d2_alu_op_ex),
    .RegWrite_ex(d2_RegWrite_ex), .MemRead_ex(d2_MemRead_ex), .MemWrite_ex(d2_MemWrite_ex),
    .MemToReg_ex(d2_MemToReg_ex), .ALUSrc_ex(d2_ALUSrc_ex), .Branch_ex(d2_Branch_ex),
    .Jump_ex(d2_Jump_ex), .stall_id(d2_stall_id), .load_use(d2_load_use),
    .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt)
  );

  // Expected contents of the EX slot: the instruction (or bubble) that should be there.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        rw, mr, mw, m2r, asrc, br, jmp;
  } slot_t;

  slot_t       m;
  int unsigned sc, fc, sc2, fc2;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic slot_t id_slot();
    return '{valid_id, pc_id, rs1_id, rs2_id, rd_id, rs1_data_id, rs2_data_id, imm_id,
             funct3_id, alu_op_id, RegWrite_id, MemRead_id, MemWrite_id, MemToReg_id,
             ALUSrc_id, Branch_id, Jump_id};
  endfunction

  function automatic logic exp_lu();
    return m.valid && m.mr && (m.rd != 0) && valid_id &&
           ((uses_rs1_id && m.rd == rs1_id) || (uses_rs2_id && m.rd == rs2_id));
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic check_all();
    logic lu;
    slot_t g2;
    lu = exp_lu();
    chk("valid_ex", valid_ex, m.valid);
    chk("pc_ex", pc_ex, m.pc);
    chk("rs1_ex", rs1_ex, m.rs1);
    chk("rs2_ex", rs2_ex, m.rs2);
    chk("rd_ex", rd_ex, m.rd);
    chk("rs1_data_ex", rs1_data_ex, m.rs1_data);
    chk("rs2_data_ex", rs2_data_ex, m.rs2_data);
    chk("imm_ex", imm_ex, m.imm);
    chk("funct3_ex", funct3_ex, m.funct3);
    chk("alu_op_ex", alu_op_ex, m.alu_op);
    chk("ctrl_ex", {RegWrite_ex, MemRead_ex, MemWrite_ex, MemToReg_ex, ALUSrc_ex, Branch_ex, Jump_ex},
        {m.rw, m.mr, m.mw, m.m2r, m.asrc, m.br, m.jmp});
    chk("load_use", load_use, lu);
    chk("stall_id", stall_id, hold | (lu & ~flush_ex));
    chk("stall_cnt", stall_cnt, sc);
    chk("flush_cnt", flush_cnt, fc);
    g2 = '{d2_valid_ex, d2_pc_ex, d2_rs1_ex, d2_rs2_ex, d2_rd_ex, d2_rs1_data_ex, d2_rs2_data_ex,
           d2_imm_ex, d2_funct3_ex, d2_alu_op_ex, d2_RegWrite_ex, d2_MemRead_ex, d2_MemWrite_ex,
           d2_MemToReg_ex, d2_ALUSrc_ex, d2_Branch_ex, d2_Jump_ex};
    chk("d2_slot", g2, m);
    chk("d2_load_use", d2_load_use, lu);
    chk("d2_stall_id", d2_stall_id, hold | (lu & ~flush_ex));
    chk("d2_stall_cnt", d2_stall_cnt, sc2);
    chk("d2_flush_cnt", d2_flush_cnt, fc2);
  endtask

  task automatic model_edge();
    logic lu;
    lu = exp_lu();
    if (rst) begin
      m = '0; sc = 0; fc = 0; sc2 = 0; fc2 = 0;
    end else if (hold) begin
      m = m;
    end else if (flush_ex) begin
      m = '0; fc = sat(fc, 65535); fc2 = sat(fc2, 3);
    end else if (lu) begin
      m = '0; sc = sat(sc, 65535); sc2 = sat(sc2, 3);
    end else begin
      m = valid_id ? id_slot() : '0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_id(input int rs_max);
    valid_id    = $urandom_range(0, 3) != 0;
    pc_id       = $urandom;
    rs1_id      = 5'($urandom_range(0, rs_max));
    rs2_id      = 5'($urandom_range(0, rs_max));
    rd_id       = 5'($urandom_range(0, rs_max));
    uses_rs1_id = 1'($urandom);
    uses_rs2_id = 1'($urandom);
    rs1_data_id = $urandom;
    rs2_data_id = $urandom;
    imm_id      = $urandom;
    funct3_id   = 3'($urandom);
    alu_op_id   = 4'($urandom);
    {RegWrite_id, MemRead_id, MemWrite_id, MemToReg_id, ALUSrc_id, Branch_id, Jump_id} = 7'($urandom);
  endtask

  task automatic instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic u1, input logic u2, input logic mr,
                       input logic [31:0] imm);
    rand_id(31);
    valid_id = 1'b1; pc_id = pc; rs1_id = rs1; rs2_id = rs2; rd_id = rd;
    uses_rs1_id = u1; uses_rs2_id = u2; imm_id = imm;
    {RegWrite_id, MemRead_id, MemWrite_id, MemToReg_id, ALUSrc_id, Branch_id, Jump_id} =
      {1'b1, mr, 1'b0, mr, 1'b1, 1'b0, 1'b0};
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush_ex = 1'b0;
    rand_id(31);
    m = '0; sc = 0; fc = 0; sc2 = 0; fc2 = 0;
    @(posedge clk);
    model_edge();
    #1;

    // Reset held two cycles with random ID inputs
    rand_id(31); step();
    rand_id(31); step();
    chk("rst_valid_ex", valid_ex, 1'b0);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_flush_cnt", flush_cnt, 16'd0);
    chk("rst_load_use", load_use, 1'b0);
    rst = 1'b0;

    // addi x5,x0,7 at 0x100
    instr(32'h100, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 32'd7);
    step();
    chk("pt_pc", pc_ex, 32'h100);
    chk("pt_rd", rd_ex, 5'd5);
    chk("pt_imm", imm_ex, 32'd7);
    chk("pt_valid", valid_ex, 1'b1);
    chk("pt_stall", stall_id, 1'b0);

    // lw x6,0(x1) ; add x7,x6,x2
    instr(32'h104, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 32'd0);
    step();
    instr(32'h108, 5'd6, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 32'd0);
    #1;
    chk("lu_detect", load_use, 1'b1);
    chk("lu_stall", stall_id, 1'b1);
    step();
    chk("lu_bubble_valid", valid_ex, 1'b0);
    chk("lu_bubble_rd", rd_ex, 5'd0);
    chk("lu_stall_cnt", stall_cnt, 16'd1);
    step();
    chk("lu_add_valid", valid_ex, 1'b1);
    chk("lu_add_rs1", rs1_ex, 5'd6);

    // lw x0 then a read of x0; lw x6 then lui x6
    instr(32'h10c, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 32'd0);
    step();
    instr(32'h110, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 32'd0);
    #1;
    chk("x0_no_lu", load_use, 1'b0);
    step();
    chk("x0_no_bubble", valid_ex, 1'b1);
    instr(32'h114, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 32'd0);
    step();
    instr(32'h118, 5'd6, 5'd6, 5'd6, 1'b0, 1'b0, 1'b0, 32'h5000);
    #1;
    chk("lui_no_lu", load_use, 1'b0);
    step();
    chk("lui_no_bubble", pc_ex, 32'h118);

    // flush together with a load-use hazard
    rst = 1'b1; step(); rst = 1'b0;
    instr(32'h120, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 32'd0);
    step();
    instr(32'h124, 5'd6, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 32'd0);
    flush_ex = 1'b1;
    #1;
    chk("fl_lu", load_use, 1'b1);
    chk("fl_stall", stall_id, 1'b0);
    step();
    flush_ex = 1'b0;
    chk("fl_bubble", valid_ex, 1'b0);
    chk("fl_flush_cnt", flush_cnt, 16'd1);
    chk("fl_stall_cnt", stall_cnt, 16'd0);

    // hold for three cycles with changing ID inputs
    instr(32'h200, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 1'b0, 32'd42);
    step();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id(31);
      #1;
      chk("hold_stall", stall_id, 1'b1);
      step();
      chk("hold_pc", pc_ex, 32'h200);
      chk("hold_imm", imm_ex, 32'd42);
    end
    hold = 1'b0;

    // four load-use events: 16-bit counter reaches 4, 2-bit counter stays at 3
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      instr(32'h300 + 32'(i * 8), 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 32'd0);
      step();
      instr(32'h304 + 32'(i * 8), 5'd6, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 32'd0);
      step();
      step();
    end
    chk("sat_cnt16", stall_cnt, 16'd4);
    chk("sat_cnt2", d2_stall_cnt, 2'd3);

    // random traffic with a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      rand_id(3);
      rst      = $urandom_range(0, 63) == 0;
      hold     = $urandom_range(0, 5) == 0;
      flush_ex = $urandom_range(0, 7) == 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
